// File: rtl/edge_check_sequencer_if.sv
// Signal bundle between the edge-check sequencer and the unit whose
// $stable/$rose/$fell results it judges.
interface edge_check_sequencer_if #(
  parameter int WIDTH = 1
);
  logic             start;
  logic             obs_valid;
  logic             obs_stable;
  logic             obs_rose;
  logic             obs_fell;
  logic [WIDTH-1:0] stim;
  logic             exp_valid;
  logic             exp_stable;
  logic             exp_rose;
  logic             exp_fell;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [7:0]       cyc;

  modport master (
    output start, obs_valid, obs_stable, obs_rose, obs_fell,
    input  stim, exp_valid, exp_stable, exp_rose, exp_fell,
    input  busy, done, pass, err_count, cyc
  );

  modport slave (
    input  start, obs_valid, obs_stable, obs_rose, obs_fell,
    output stim, exp_valid, exp_stable, exp_rose, exp_fell,
    output busy, done, pass, err_count, cyc
  );
endinterface

// File: rtl/edge_check_sequencer.sv
// Drives a toggle / hold / one-cycle-pulse pattern on stim, derives the expected
// sampled-value results each cycle and counts cycles where the observed results disagree.
module edge_check_sequencer #(
  parameter int WIDTH      = 1,
  parameter int TOGGLE_LEN = 6,
  parameter int HOLD_LEN   = 3
) (
  input logic                  clk,
  input logic                  rst,
  edge_check_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, TOGGLE, HOLD, PULSE1, PULSE2, DONE} state_t;

  // Phase boundaries expressed as the run-cycle index of each phase's last cycle.
  localparam logic [7:0] TOGGLE_END = 8'(TOGGLE_LEN);
  localparam logic [7:0] HOLD_END   = 8'(TOGGLE_LEN + HOLD_LEN);

  state_t           state;
  logic [WIDTH-1:0] stim;
  logic [WIDTH-1:0] prev;
  logic [7:0]       cyc;
  logic [15:0]      err_count;
  logic             busy;
  logic             done;
  logic             pass;

  logic             exp_stable;
  logic             exp_rose;
  logic             exp_fell;
  logic             mismatch;
  logic [15:0]      err_next;

  always_comb begin
    exp_stable = (stim == prev);
    exp_rose   = !prev[0] && stim[0];
    exp_fell   = prev[0] && !stim[0];
    mismatch   = busy && bus.obs_valid &&
                 ((bus.obs_stable != exp_stable) ||
                  (bus.obs_rose   != exp_rose)   ||
                  (bus.obs_fell   != exp_fell));
    err_next   = err_count;
    if (mismatch && (err_count != 16'hFFFF)) err_next = err_count + 16'd1;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; a later assignment in the same block overrides
  // an earlier default (used for prev on the start edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stim      <= '0;
      prev      <= '0;
      cyc       <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      prev <= stim;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= TOGGLE;
            stim      <= '1;
            prev      <= '0;
            cyc       <= 8'd1;
            err_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        TOGGLE: begin
          cyc       <= cyc + 8'd1;
          err_count <= err_next;
          if (cyc == TOGGLE_END) begin
            if (HOLD_LEN == 0) begin
              state <= PULSE1;
              stim  <= ~stim;
            end else begin
              state <= HOLD;
            end
          end else begin
            stim <= ~stim;
          end
        end
        HOLD: begin
          cyc       <= cyc + 8'd1;
          err_count <= err_next;
          if (cyc == HOLD_END) begin
            state <= PULSE1;
            stim  <= ~stim;
          end
        end
        PULSE1: begin
          cyc       <= cyc + 8'd1;
          err_count <= err_next;
          state     <= PULSE2;
          stim      <= ~stim;
        end
        PULSE2: begin
          err_count <= err_next;
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          pass      <= (err_next == 16'd0);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stim       = stim;
  assign bus.exp_valid  = busy;
  assign bus.exp_stable = exp_stable;
  assign bus.exp_rose   = exp_rose;
  assign bus.exp_fell   = exp_fell;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.err_count  = err_count;
  assign bus.cyc        = cyc;

endmodule

// File: tb/tb_edge_check_sequencer.sv
// Scoreboard bench: two sequencer configurations, a pattern-level reference model
// producing expected records, and a negedge monitor that pops and compares them.
module tb_edge_check_sequencer;

  localparam int W0 = 3, T0 = 6, H0 = 3;
  localparam int W1 = 1, T1 = 1, H1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edge_check_sequencer_if #(.WIDTH(W0)) bus0 ();
  edge_check_sequencer_if #(.WIDTH(W1)) bus1 ();

  edge_check_sequencer #(.WIDTH(W0), .TOGGLE_LEN(T0), .HOLD_LEN(H0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  edge_check_sequencer #(.WIDTH(W1), .TOGGLE_LEN(T1), .HOLD_LEN(H1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    int cyc;
    bit s;
    bit st;
    bit ro;
    bit fe;
    int err;
    bit is_done;
    bit pass;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done_q[2];

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Pattern value of stim during run cycle c (1-based), straight from the phase rules.
  function automatic bit model_stim(input int t, input int h, input int c);
    bit held;
    held = (t % 2) == 1;
    if (c <= t)         return (c % 2) == 1;
    if (c <= t + h)     return held;
    if (c == t + h + 1) return !held;
    return held;
  endfunction

  task automatic set_in(input int u, input bit st, input bit ov, input bit os, input bit obr, input bit obf);
    if (u == 0) begin
      bus0.start = st; bus0.obs_valid = ov; bus0.obs_stable = os;
      bus0.obs_rose = obr; bus0.obs_fell = obf;
    end else begin
      bus1.start = st; bus1.obs_valid = ov; bus1.obs_stable = os;
      bus1.obs_rose = obr; bus1.obs_fell = obf;
    end
  endtask

  // Everything that must read zero in IDLE, packed into one word.
  task automatic check_idle(input int u, input string name);
    longint v;
    if (u == 0)
      v = {bus0.busy, bus0.done, bus0.pass, bus0.exp_valid, 32'(bus0.stim), bus0.cyc, bus0.err_count};
    else
      v = {bus1.busy, bus1.done, bus1.pass, bus1.exp_valid, 32'(bus1.stim), bus1.cyc, bus1.err_count};
    check(name, v, 0);
  endtask

  task automatic judge(input int u, input bit valid, input bit done, input bit busy, input bit pass,
                       input logic [31:0] stim, input bit st, input bit ro, input bit fe,
                       input logic [15:0] err, input logic [7:0] cyc, input int w);
    exp_t   e;
    string  tag;
    int     qn;
    longint mask;
    tag  = (u == 0) ? "u0" : "u1";
    mask = (longint'(1) << w) - 1;
    if (valid || (done && !done_q[u])) begin
      qn = (u == 0) ? sb0.size() : sb1.size();
      if (qn == 0) begin
        check({tag, ".unexpected_output"}, qn, 1);
      end else begin
        if (u == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check({tag, ".done"}, done, e.is_done);
        check({tag, ".busy"}, busy, !e.is_done);
        check({tag, ".cyc"}, cyc, e.cyc);
        check({tag, ".err_count"}, err, e.err);
        check({tag, ".stim"}, stim, e.s ? mask : 0);
        if (e.is_done) begin
          check({tag, ".pass"}, pass, e.pass);
        end else begin
          check({tag, ".exp_stable"}, st, e.st);
          check({tag, ".exp_rose"}, ro, e.ro);
          check({tag, ".exp_fell"}, fe, e.fe);
        end
      end
    end
    done_q[u] = done;
  endtask

  always @(negedge clk) begin
    judge(0, bus0.exp_valid, bus0.done, bus0.busy, bus0.pass, 32'(bus0.stim), bus0.exp_stable,
          bus0.exp_rose, bus0.exp_fell, bus0.err_count, bus0.cyc, W0);
    judge(1, bus1.exp_valid, bus1.done, bus1.busy, bus1.pass, 32'(bus1.stim), bus1.exp_stable,
          bus1.exp_rose, bus1.exp_fell, bus1.err_count, bus1.cyc, W1);
  end

  // mode 0: ideal UUT, 1: random valid/flips, 2: obs_stable inverted through HOLD.
  task automatic do_run(input int u, input int mode, input int rst_at, input int busy_start_at);
    int     t, h, len, errs;
    bit     s, p, st, ro, fe, ov;
    bit [2:0] flip;
    exp_t   e;
    t    = (u == 0) ? T0 : T1;
    h    = (u == 0) ? H0 : H1;
    len  = t + h + 2;
    errs = 0;
    set_in(u, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int c = 1; c <= len; c++) begin
      s  = model_stim(t, h, c);
      p  = (c == 1) ? 1'b0 : model_stim(t, h, c - 1);
      st = (s == p);
      ro = !p && s;
      fe = p && !s;
      e.cyc = c; e.s = s; e.st = st; e.ro = ro; e.fe = fe;
      e.err = errs; e.is_done = 1'b0; e.pass = 1'b0;
      if (u == 0) sb0.push_back(e); else sb1.push_back(e);
      ov   = 1'b1;
      flip = 3'd0;
      if (mode == 1) begin
        ov = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 4) == 0) flip = 3'($urandom_range(1, 7));
      end else if (mode == 2) begin
        if (c > t && c <= t + h) flip = 3'b100;
      end
      set_in(u, c == busy_start_at, ov, st ^ flip[2], ro ^ flip[1], fe ^ flip[0]);
      if (c == rst_at) rst = 1'b1;
      if (ov && flip != 3'd0 && errs < 65535) errs++;
      @(posedge clk); #1;
      if (c == rst_at) begin
        rst = 1'b0;
        set_in(u, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_idle(u, (u == 0) ? "u0.midrun_reset" : "u1.midrun_reset");
        return;
      end
    end
    e.cyc = len; e.s = model_stim(t, h, len); e.st = 1'b0; e.ro = 1'b0; e.fe = 1'b0;
    e.err = errs; e.is_done = 1'b1; e.pass = (errs == 0);
    if (u == 0) sb0.push_back(e); else sb1.push_back(e);
    set_in(u, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle(0, "u0.reset");
    check_idle(1, "u1.reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "u0.idle_no_start");
    check_idle(1, "u1.idle_no_start");

    rst = 1'b1;
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_idle(0, "u0.start_with_rst");

    do_run(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_run(0, 2, 0, 0);
    do_run(0, 0, 0, 0);
    do_run(0, 0, 0, 4);
    do_run(0, 1, 5, 0);
    do_run(0, 0, 0, 0);
    do_run(1, 0, 0, 0);
    do_run(1, 1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      do_run(int'($urandom_range(0, 1)), 1, 0, int'($urandom_range(0, 8)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("u0.scoreboard_drained", sb0.size(), 0);
    check("u1.scoreboard_drained", sb1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
